// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word-aligned fetch at a time, tracks the
// in-flight request through a REQ/WAIT/DROP FSM, and hands responses to the
// IF/ID register through a single-entry skid buffer so that ID stalls never
// lose an instruction. Redirects restart fetch and squash in-flight work.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall_id,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  // addi x0, x0, 0: presented to the decoder whenever IF/ID holds nothing
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] req_pc;

  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;

  logic        grant;
  logic        resp;
  logic        consume;
  logic        id_free;

  // A full skid buffer means ID is backed up; stop fetching until it drains.
  assign imem_req  = (state == S_REQ) && !skid_valid;
  assign imem_addr = pc_q;

  assign grant   = imem_req && imem_gnt;
  assign resp    = (state == S_WAIT) && imem_rvalid;
  assign consume = id_valid && !stall_id;
  assign id_free = !id_valid || consume;

  // Request FSM and fetch PC; a redirect overrides everything and decides
  // whether an old-path response is still owed (DROP) or not (REQ).
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      pc_q   <= RESET_PC;
      req_pc <= 32'h0;
    end else if (redirect) begin
      pc_q <= redirect_pc & ~32'h3;
      case (state)
        S_REQ:   state <= grant ? S_DROP : S_REQ;
        default: state <= imem_rvalid ? S_REQ : S_DROP;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (grant) begin
            req_pc <= pc_q;
            pc_q   <= pc_q + 32'd4;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) state <= S_REQ;
        end
        S_DROP: begin
          if (imem_rvalid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // IF/ID register and skid buffer; the buffer always drains ahead of a
  // same-cycle response so program order is preserved.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid   <= 1'b0;
      id_pc      <= 32'h0;
      id_instr   <= NOP;
      skid_valid <= 1'b0;
    end else if (redirect) begin
      id_valid   <= 1'b0;
      id_instr   <= NOP;
      skid_valid <= 1'b0;
    end else if (id_free) begin
      if (skid_valid) begin
        id_valid <= 1'b1;
        id_pc    <= skid_pc;
        id_instr <= skid_instr;
        if (resp) begin
          skid_pc    <= req_pc;
          skid_instr <= imem_rdata;
        end else begin
          skid_valid <= 1'b0;
        end
      end else if (resp) begin
        id_valid <= 1'b1;
        id_pc    <= req_pc;
        id_instr <= imem_rdata;
      end else begin
        id_valid <= 1'b0;
      end
    end else if (resp) begin
      skid_valid <= 1'b1;
      skid_pc    <= req_pc;
      skid_instr <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural instruction memory with variable
// latency drives the DUT, and a transaction-level reference (expected next
// fetch address, expected next delivered PC) checks every fetch and every
// instruction consumed by ID. Directed steps first, then random traffic.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall_id;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  int total = 0;
  int bad   = 0;

  // memory model state
  bit          pend;
  int          cnt;
  logic [31:0] pend_addr;

  // reference model state
  logic [31:0] exp_fetch;
  logic [31:0] next_dlv;
  bit          hold_prev;
  logic [31:0] hp_pc;
  logic [31:0] hp_instr;
  bit          rd_prev;
  int          ndeliv;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall_id    (stall_id),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check current outputs, drive inputs, advance the model.
  task automatic step(input bit g, input int dly, input bit st, input bit rd,
                      input logic [31:0] tgt);
    bit resp;
    bit grant;
    if (rd_prev) begin
      chk("redir_vld", {31'h0, id_valid}, 32'h0);
      chk("redir_nop", id_instr, NOP);
    end
    if (hold_prev) begin
      chk("hold_vld", {31'h0, id_valid}, 32'h1);
      chk("hold_pc", id_pc, hp_pc);
      chk("hold_instr", id_instr, hp_instr);
    end
    if (pend) chk("one_outstanding", {31'h0, imem_req}, 32'h0);
    if (imem_req) chk("fetch_addr", imem_addr, exp_fetch);

    resp        = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem(pend_addr);
        resp        = 1'b1;
      end else begin
        cnt--;
      end
    end
    grant       = imem_req && g && !pend;
    imem_gnt    = g;
    stall_id    = st;
    redirect    = rd;
    redirect_pc = tgt;

    if (id_valid && !st && !rd) begin
      chk("dlv_pc", id_pc, next_dlv);
      chk("dlv_instr", id_instr, mem(next_dlv));
      next_dlv = next_dlv + 32'd4;
      ndeliv++;
    end
    hold_prev = id_valid && st && !rd;
    hp_pc     = id_pc;
    hp_instr  = id_instr;
    rd_prev   = rd;
    if (resp) pend = 1'b0;
    if (grant) begin
      pend      = 1'b1;
      cnt       = dly - 1;
      pend_addr = imem_addr;
    end
    if (rd) begin
      exp_fetch = tgt & ~32'h3;
      next_dlv  = tgt & ~32'h3;
    end else if (grant) begin
      exp_fetch = exp_fetch + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall_id    = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    pend      = 1'b0;
    cnt       = 0;
    exp_fetch = RESET_PC;
    next_dlv  = RESET_PC;
    hold_prev = 1'b0;
    rd_prev   = 1'b0;
    chk("rst_req", {31'h0, imem_req}, 32'h1);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_vld", {31'h0, id_valid}, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_instr", id_instr, NOP);
  endtask

  // Idle cycles until the DUT is ready to issue a request (bounded).
  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req; i++) step(1'b0, 1, 1'b0, 1'b0, 32'h0);
    chk("wait_req_timeout", {31'h0, imem_req}, 32'h1);
  endtask

  initial begin
    int base;
    ndeliv = 0;
    do_reset();
    do_reset();

    // Streaming fetch: one instruction every two cycles.
    for (int i = 0; i < 7; i++) step(1'b1, 1, 1'b0, 1'b0, 32'h0);
    chk("stream_rate", ndeliv, 3);
    chk("stream_next", next_dlv, 32'hC);

    // ID stall: IF/ID holds, next response parks in skid, fetching stops.
    for (int i = 0; i < 5; i++) step(1'b1, 1, 1'b1, 1'b0, 32'h0);
    chk("skid_full_noreq", {31'h0, imem_req}, 32'h0);
    base = ndeliv;
    for (int i = 0; i < 6; i++) step(1'b1, 1, 1'b0, 1'b0, 32'h0);
    chk("skid_drain", {31'h0, ndeliv - base >= 2}, 32'h1);

    // Redirect while waiting on a response.
    wait_req();
    step(1'b1, 3, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1, 1'b0, 1'b1, 32'h0000_0103);
    chk("redir_wait_addr", imem_addr, 32'h0000_0100);
    base = ndeliv;
    for (int i = 0; i < 12; i++) step(1'b1, 1, 1'b0, 1'b0, 32'h0);
    chk("redir_wait_resume", {31'h0, ndeliv > base}, 32'h1);

    // Redirect coincident with a grant: old-path response must be dropped.
    wait_req();
    step(1'b1, 2, 1'b0, 1'b1, 32'h0000_0200);
    chk("redir_gnt_drop_req", {31'h0, imem_req}, 32'h0);
    chk("redir_gnt_addr", imem_addr, 32'h0000_0200);
    for (int i = 0; i < 12; i++) step(1'b1, 1, 1'b0, 1'b0, 32'h0);

    // PC wrap at the top of the address space.
    wait_req();
    step(1'b0, 1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_req();
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 2, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 10; i++) step(1'b1, 1, 1'b0, 1'b0, 32'h0);

    // Reset mid-transaction with a late response arriving afterwards.
    wait_req();
    step(1'b1, 5, 1'b0, 1'b0, 32'h0);
    do_reset();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    chk("late_rvalid_vld", {31'h0, id_valid}, 32'h0);
    chk("late_rvalid_req", {31'h0, imem_req}, 32'h1);
    chk("late_rvalid_addr", imem_addr, RESET_PC);
    for (int i = 0; i < 8; i++) step(1'b1, 1, 1'b0, 1'b0, 32'h0);

    // Random traffic against the reference model.
    base = ndeliv;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step($urandom_range(0, 99) < 70, $urandom_range(1, 3), $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 4, tgt);
    end
    chk("random_progress", {31'h0, ndeliv - base > 200}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_req  output  1  fetch request valid.
REQ-005 imem_addr  output  32  fetch address, word-aligned.
REQ-006 imem_gnt  input  1  memory accepts request this cycle (effective only when imem_req=1).
REQ-007 imem_rvalid  input  1  response data valid; at least 1 cycle after grant.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 redirect  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-010 redirect_pc  input  32  target address; bits [1:0] forced to 0 internally.
REQ-011 stall_id  input  1  ID stage cannot accept a new instruction this cycle.
REQ-012 id_valid  output  1  IF/ID register holds a valid instruction.
REQ-013 id_pc  output  32  PC of id_instr.
REQ-014 id_instr  output  32  instruction presented to decoder and immediate generator (bits [31:7]).

Function
REQ-015 At most one memory request SHALL be outstanding; a request is issued when imem_req&&imem_gnt.
REQ-016 FSM states SHALL be REQ, WAIT, DROP.
REQ-017 REQ: imem_req=1 iff skid buffer empty; imem_addr=pc_q; on grant, req_pc<=pc_q, pc_q<=pc_q+4 (mod 2^32 wrap), next state WAIT.
REQ-018 WAIT: imem_req=0; on imem_rvalid, response {req_pc, imem_rdata} SHALL be delivered (REQ-021), next state REQ.
REQ-019 DROP: imem_req=0; on imem_rvalid, response SHALL be discarded, next state REQ.
REQ-020 imem_rvalid in state REQ SHALL be ignored.
REQ-021 Delivery: ID consumes when id_valid && !stall_id; if IF/ID register empty or consumed this cycle, response loads IF/ID directly (id_valid=1 next cycle); otherwise response loads the 1-entry skid buffer.
REQ-022 When IF/ID is empty or consumed and skid buffer valid, IF/ID SHALL load from the skid buffer (buffer has priority over a same-cycle response, which then enters the buffer).
REQ-023 When IF/ID is consumed and no data is available, id_valid SHALL clear next cycle.
REQ-024 While stall_id=1 and id_valid=1, id_valid/id_pc/id_instr SHALL hold unchanged.
REQ-025 Latency: grant at cycle N, rvalid at cycle M, IF/ID empty -> id_valid=1 with data at cycle M+1; next grant possible at cycle M+1.
REQ-026 Redirect (priority over stall and delivery): pc_q<=redirect_pc&~3; id_valid<=0; skid buffer cleared; id_instr<=32'h0000_0013.
REQ-027 Redirect in REQ without grant: stay REQ; imem_addr=redirect target from next cycle.
REQ-028 Redirect in REQ with simultaneous grant: granted (old-path) request SHALL be dropped; next state DROP.
REQ-029 Redirect in WAIT without rvalid: next state DROP; with rvalid: data discarded, next state REQ.
REQ-030 Redirect in DROP: pc_q updated, remain DROP until rvalid.
REQ-031 Instruction order SHALL be preserved; no instruction delivered twice or skipped except by redirect.

Reset
REQ-032 On rst=1 at a clock edge: pc_q=RESET_PC, state=REQ, id_valid=0, id_pc=0, id_instr=32'h0000_0013, skid buffer invalid, req_pc=0.
REQ-033 Reset mid-transaction SHALL abandon the outstanding request; a late rvalid arrives in REQ and is ignored (REQ-020).
REQ-034 imem_req SHALL be 1 in the first cycle after rst deasserts, with imem_addr=RESET_PC.

Verification
REQ-035 Reset release, gnt=1 each request, rvalid 1 cycle after grant, stall_id=0 -> id_pc 0x0,0x4,0x8 one instruction per 2 cycles, id_instr matches memory.
REQ-036 stall_id=1 for 5 cycles while id_valid=1 -> id_instr/id_pc stable; next response goes to skid buffer, imem_req=0; on release both delivered in order, no loss.
REQ-037 Redirect to 0x0000_0103 while in WAIT -> in-flight rdata discarded, next imem_addr=0x0000_0100, id_valid=0 until its response.
REQ-038 Redirect coincident with grant of 0x8 -> DROP; response for 0x8 never appears on id_*; next request addr=target.
REQ-039 pc_q=0xFFFF_FFFC granted -> next imem_addr=0x0000_0000.
REQ-040 rst asserted in WAIT, rvalid arrives 2 cycles later -> ignored; id_valid=0; first request addr=RESET_PC.
